// File: rtl/csr_file_pkg.sv
// csr_file_pkg -- shared definitions for the machine-mode CSR file.
//   CSR address constants, csr_alu_ctr operation encodings, mstatus bit
//   positions and a helper that builds the architectural mstatus read value.
//   Counter addresses are always defined here; whether they are mapped is
//   decided in csr_file by the CSR_COUNTERS_EN macro.
package csr_file_pkg;

  localparam logic [11:0] ADDR_MSTATUS   = 12'h300;
  localparam logic [11:0] ADDR_MTVEC     = 12'h305;
  localparam logic [11:0] ADDR_MSCRATCH  = 12'h340;
  localparam logic [11:0] ADDR_MEPC      = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE    = 12'h342;
  localparam logic [11:0] ADDR_MCYCLE    = 12'hB00;
  localparam logic [11:0] ADDR_MINSTRET  = 12'hB02;
  localparam logic [11:0] ADDR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] ADDR_MINSTRETH = 12'hB82;

  // Odd codes take the zero-extended immediate, even codes take rs1_data.
  typedef enum logic [2:0] {
    OP_RW  = 3'b000,
    OP_RWI = 3'b001,
    OP_RS  = 3'b010,
    OP_RSI = 3'b011,
    OP_RC  = 3'b100,
    OP_RCI = 3'b101
  } csr_op_e;

  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_LO = 11;
  localparam int MSTATUS_MPP_HI = 12;

  localparam logic [31:0] MSTATUS_RESET = 32'h0000_1800;

  // Only MIE/MPIE are stored; MPP is hardwired to machine mode (2'b11).
  function automatic logic [31:0] mstatus_pack(input logic mie, input logic mpie);
    logic [31:0] v;
    v = '0;
    v[MSTATUS_MIE] = mie;
    v[MSTATUS_MPIE] = mpie;
    v[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
    return v;
  endfunction

endpackage

// File: rtl/csr_file_alu.sv
// csr_alu -- combinational CSR read-modify-write operation.
//   op       : csr_alu_ctr encoding (see csr_op_e)
//   old_val  : current CSR value
//   rs1_data : register source operand
//   zimm     : 5-bit immediate, zero-extended for the odd (immediate) codes
//   new_val  : value to commit; codes 110/111 return old_val unchanged
module csr_alu
  import csr_file_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] old_val,
  input  logic [31:0] rs1_data,
  input  logic [4:0]  zimm,
  output logic [31:0] new_val
);

  logic [31:0] src;

  always_comb begin
    src = op[0] ? {27'b0, zimm} : rs1_data;
    new_val = old_val;
    case (op)
      OP_RW,  OP_RWI: new_val = src;
      OP_RS,  OP_RSI: new_val = old_val | src;
      OP_RC,  OP_RCI: new_val = old_val & ~src;
      default:        new_val = old_val;
    endcase
  end

endmodule

// File: rtl/csr_file.sv
// csr_file -- machine-mode CSR file (mstatus, mtvec, mscratch, mepc, mcause).
//   Optional feature macro: CSR_COUNTERS_EN adds mcycle[h]/minstret[h].
// Ports:
//   clk, rst          : rising-edge clock, async active-high reset
//   csr_we            : commit the CSR instruction at this edge
//   csr_alu_ctr       : RW/RWI/RS/RSI/RC/RCI operation select
//   csr_addr          : CSR address (instr[31:20])
//   rs1_data, zimm    : operation sources
//   csr_rdata         : pre-write value of csr_addr (0 if unmapped)
//   trap_valid/cause/pc : synchronous exception entry
//   mret              : return from trap
//   instr_retire      : retirement pulse for minstret
//   trap_vector       : {mtvec[31:2],2'b00}
//   mepc_out          : registered mepc, the MRET target
// No handshake: every input is sampled at each rising edge, and the
// priority among updates is trap_valid > mret > csr_we.
module csr_file
  import csr_file_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        csr_we,
  input  logic [2:0]  csr_alu_ctr,
  input  logic [11:0] csr_addr,
  input  logic [31:0] rs1_data,
  input  logic [4:0]  zimm,
  output logic [31:0] csr_rdata,
  input  logic        trap_valid,
  input  logic [31:0] trap_cause,
  input  logic [31:0] trap_pc,
  input  logic        mret,
  input  logic        instr_retire,
  output logic [31:0] trap_vector,
  output logic [31:0] mepc_out
);

  logic        mie_q;
  logic        mpie_q;
  logic [29:0] mtvec_q;   // bits [1:0] are hardwired zero
  logic [31:0] mscratch_q;
  logic [29:0] mepc_q;    // bits [1:0] are hardwired zero
  logic [31:0] mcause_q;

  logic [31:0] new_val;
  logic        wr_en;

`ifdef CSR_COUNTERS_EN
  logic [63:0] mcycle_q;
  logic [63:0] minstret_q;
`endif

  // A write only lands when neither trap nor mret claims the cycle.
  assign wr_en = csr_we & ~trap_valid & ~mret;

  always_comb begin
    csr_rdata = '0;
    case (csr_addr)
      ADDR_MSTATUS:   csr_rdata = mstatus_pack(mie_q, mpie_q);
      ADDR_MTVEC:     csr_rdata = {mtvec_q, 2'b00};
      ADDR_MSCRATCH:  csr_rdata = mscratch_q;
      ADDR_MEPC:      csr_rdata = {mepc_q, 2'b00};
      ADDR_MCAUSE:    csr_rdata = mcause_q;
`ifdef CSR_COUNTERS_EN
      ADDR_MCYCLE:    csr_rdata = mcycle_q[31:0];
      ADDR_MCYCLEH:   csr_rdata = mcycle_q[63:32];
      ADDR_MINSTRET:  csr_rdata = minstret_q[31:0];
      ADDR_MINSTRETH: csr_rdata = minstret_q[63:32];
`endif
      default:        csr_rdata = '0;
    endcase
  end

  csr_alu u_alu (
    .op       (csr_alu_ctr),
    .old_val  (csr_rdata),
    .rs1_data (rs1_data),
    .zimm     (zimm),
    .new_val  (new_val)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mie_q      <= 1'b0;
      mpie_q     <= 1'b0;
      mtvec_q    <= '0;
      mscratch_q <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
    end else if (trap_valid) begin
      mepc_q   <= trap_pc[31:2];
      mcause_q <= trap_cause;
      mpie_q   <= mie_q;
      mie_q    <= 1'b0;
    end else if (mret) begin
      mie_q  <= mpie_q;
      mpie_q <= 1'b1;
    end else if (wr_en) begin
      case (csr_addr)
        ADDR_MSTATUS: begin
          mie_q  <= new_val[MSTATUS_MIE];
          mpie_q <= new_val[MSTATUS_MPIE];
        end
        ADDR_MTVEC:    mtvec_q    <= new_val[31:2];
        ADDR_MSCRATCH: mscratch_q <= new_val;
        ADDR_MEPC:     mepc_q     <= new_val[31:2];
        ADDR_MCAUSE:   mcause_q   <= new_val;
        default: ;
      endcase
    end
  end

`ifdef CSR_COUNTERS_EN
  // A write to either half replaces it and suppresses that counter's
  // increment for the cycle; the other half holds.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcycle_q   <= '0;
      minstret_q <= '0;
    end else begin
      if (wr_en && csr_addr == ADDR_MCYCLE)
        mcycle_q[31:0] <= new_val;
      else if (wr_en && csr_addr == ADDR_MCYCLEH)
        mcycle_q[63:32] <= new_val;
      else
        mcycle_q <= mcycle_q + 64'd1;

      if (wr_en && csr_addr == ADDR_MINSTRET)
        minstret_q[31:0] <= new_val;
      else if (wr_en && csr_addr == ADDR_MINSTRETH)
        minstret_q[63:32] <= new_val;
      else if (instr_retire)
        minstret_q <= minstret_q + 64'd1;
    end
  end

  logic unused_bits;
  assign unused_bits = ^trap_pc[1:0];
`else
  logic unused_bits;
  assign unused_bits = ^{trap_pc[1:0], instr_retire};
`endif

  assign trap_vector = {mtvec_q, 2'b00};
  assign mepc_out    = {mepc_q, 2'b00};

endmodule
